posit_add_sched: RTL and testbench
==================================

# posit_add_sched

Round-robin scheduler sharing one pipelined posit adder between NREQ requesters. Each cycle it grants at most one valid request, drives that requester's operands onto the adder inputs, and carries a requester tag down a shadow pipeline matched to the adder latency so every result returns on a shared result bus labelled with its owner. It sits between the posit compute lanes and the single posit adder instance, which is external to this block.

## Interface
- NREQ, 4: number of requesters, 2..16
- WIDTH, 7: posit width; must match the adder
- EN, 1: exponent-field size; passed through for consistency with the adder, unused internally
- LAT, 2: adder latency in cycles from operand issue to valid `add_q`, >=1
- IDW, $clog2(NREQ): requester id width (localparam)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous and active-high
- req_valid  in  NREQ  request pending per requester
- req_a  in  NREQ*WIDTH  operand a; requester i occupies bits [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand b, same packing as req_a
- req_ready  out  NREQ  one-hot grant; request i is consumed when req_valid[i] && req_ready[i]
- pause  in  1  stop issuing new operations; in-flight operations still complete
- add_a  out  WIDTH  operand a to the adder
- add_b  out  WIDTH  operand b to the adder
- add_q  in  WIDTH  adder result, LAT cycles after issue
- res_valid  out  1  result on res_q / res_id is valid this cycle
- res_id  out  IDW  requester that owns the result
- res_q  out  WIDTH  result value
- busy  out  1  at least one operation in flight

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN when any req_valid is set and pause=0.
  - RUN -> DRAIN when pause=1 and the tag pipe is non-empty.
  - RUN -> IDLE when pause=1 and the pipe is empty, or when no requests are pending and the pipe is empty.
  - DRAIN -> IDLE when the pipe is empty.
  - DRAIN -> RUN is not allowed; the block always passes through IDLE.
- Grants:
  - Issue is permitted when state is IDLE or RUN, pause=0, and any req_valid is set. Issuing in IDLE adds no bubble.
  - The granted requester is the first requester with req_valid set, scanning from `ptr` upward with wrap-around.
  - On a grant, ptr <= (grant+1) mod NREQ. Without a grant, ptr holds.
- req_ready is combinational from req_valid, ptr, pause and state. It is all-zero when no issue occurs.
- add_a / add_b carry the granted requester's operands. With no grant they are 0, so the adder sees a posit zero.
- Tag pipe: LAT stages of {valid, id}. Stage 0 loads {issue, grant_id}; each later stage shifts every cycle.
- Result outputs:
  - res_valid = valid bit of the last stage.
  - res_id = id of the last stage.
  - res_q = add_q when res_valid is 1, otherwise 0.
- The result bus has no backpressure. Requesters must accept every result addressed to them.
- busy = OR of all tag-pipe valid bits.
- Requesters may hold req_valid with changing operands. Only the values present in the grant cycle are used.

## Timing
- Reset values: state=IDLE, ptr=0, tag pipe cleared. Consequently req_ready=0 until the first evaluation after reset deassertion, res_valid=0, res_id=0, res_q=0, busy=0, add_a=add_b=0.
- Latency: a grant in cycle t produces res_valid=1 in cycle t+LAT.
- Throughput: one issue per cycle, with no bubbles between back-to-back grants.
- pause sampled at 1 in cycle t: no grant in cycle t. Results issued before t still emerge on schedule.
- Reset asserted mid-operation: all in-flight tags are discarded and no stale res_valid is produced afterwards. The adder's own pipeline contents are ignored.
- A single requester holding req_valid is granted every cycle. With all NREQ valid, each requester is granted exactly once every NREQ cycles.
- ptr wrap: a grant to NREQ-1 sets ptr to 0.

## Structure
- Shared package `common`:
  - typedef enum for sched state {IDLE, RUN, DRAIN}
  - packed struct sched_tag_t {valid, id}
- Sub-module `rr_arbiter`, parameterised on N:
  - inputs: req, ptr, en
  - outputs: one-hot grant, grant_id, any
- Top level holds the FSM, ptr register, operand mux and tag shift register.

## Test plan
Bench adder model: q = a+b mod 2^WIDTH, delayed LAT=2 cycles. Configuration: NREQ=4, WIDTH=7.

- Single request: req_valid=4'b0010, a=7'h20, b=7'h20 for 1 cycle -> req_ready=4'b0010 in the same cycle; 2 cycles later res_valid=1, res_id=1, res_q=7'h40.
- All four requesters valid continuously from ptr=0 -> grant order 0,1,2,3,0,1...; res_id follows the same sequence offset by 2 cycles, with no gaps.
- req_valid=4'b1001 with ptr=3 -> grants 3, then 0, then 3 (wrap-around fairness).
- Four back-to-back issues, then pause=1 -> no further req_ready; state goes RUN -> DRAIN -> IDLE; the 2 in-flight results still emerge; busy falls the cycle after the last res_valid.
- rst pulsed asynchronously (mid-cycle) with 2 operations in flight -> res_valid, busy and req_ready immediately 0; no result appears in the following 4 cycles; after release, the first grant goes to the lowest valid index starting from 0.
- pause=1 from reset with req_valid=4'b1111 -> req_ready stays 0, state stays IDLE, add_a=add_b=0.

Source files
------------

// File: rtl/posit_add_sched_pkg.sv
// Shared types for the posit adder scheduler: FSM state encoding and the
// {valid, id} tag carried alongside each operation through the adder latency.
package posit_add_sched_pkg;

    // Wide enough for the largest supported requester count (16).
    localparam int TAG_IDW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
    } sched_tag_t;

endpackage

// File: rtl/posit_add_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first set request at or above ptr_i,
// wrapping around, and raises the one-hot grant only when en_i is set.
module rr_arbiter #(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    input  logic           en_i,
    output logic [N-1:0]   grant_o,
    output logic [IDW-1:0] grant_id_o,
    output logic           any_o
);

    logic found;
    int   idx;

    always_comb begin
        grant_o    = '0;
        grant_id_o = '0;
        found      = 1'b0;
        idx        = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr_i) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                grant_id_o = IDW'(idx);
            end
        end
        if (en_i && found) begin
            grant_o[grant_id_o] = 1'b1;
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/posit_add_sched.sv
// Shares one external pipelined posit adder between NREQ requesters: round-robin
// issue, operand mux, and a tag shift register that labels each returning result.
module posit_add_sched
    import posit_add_sched_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 7,
    parameter  int EN    = 1,
    parameter  int LAT   = 2,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  pause,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    input  logic [WIDTH-1:0]      add_q,
    output logic                  res_valid,
    output logic [IDW-1:0]        res_id,
    output logic [WIDTH-1:0]      res_q,
    output logic                  busy
);

    if (NREQ < 2 || NREQ > 16 || LAT < 1 || EN < 0 || EN >= WIDTH) begin : g_bad_cfg
        $error("posit_add_sched: unsupported parameter combination");
    end

    sched_state_e         state_q;
    logic [IDW-1:0]       ptr_q;
    sched_tag_t           tag_q [LAT];

    logic                 issue_en;
    logic                 issue;
    logic                 any_req;
    logic [IDW-1:0]       grant_id;
    logic [TAG_IDW-1:0]   grant_tag_id;
    sched_tag_t           last_tag;

    // Reset is folded in so no grant is shown while the block is held in reset.
    assign issue_en = !rst && !pause && (state_q != DRAIN);
    assign issue    = issue_en && any_req;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req_i      (req_valid),
        .ptr_i      (ptr_q),
        .en_i       (issue_en),
        .grant_o    (req_ready),
        .grant_id_o (grant_id),
        .any_o      (any_req)
    );

    always_comb begin
        add_a = '0;
        add_b = '0;
        if (issue) begin
            add_a = req_a[int'(grant_id)*WIDTH +: WIDTH];
            add_b = req_b[int'(grant_id)*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        grant_tag_id           = '0;
        grant_tag_id[IDW-1:0]  = grant_id;
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            busy = busy | tag_q[i].valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req && !pause) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_q <= busy ? DRAIN : IDLE;
                    end else if (!any_req && !busy) begin
                        state_q <= IDLE;
                    end
                end
                DRAIN: begin
                    if (!busy) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (issue) begin
                ptr_q <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
            end

            // Stage 0 records every cycle so idle cycles push empty tags along.
            tag_q[0].valid <= issue;
            tag_q[0].id    <= grant_tag_id;
            for (int i = 1; i < LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign last_tag  = tag_q[LAT-1];
    assign res_valid = last_tag.valid;
    assign res_id    = last_tag.id[IDW-1:0];
    assign res_q     = last_tag.valid ? add_q : '0;

endmodule

// File: tb/tb_posit_add_sched.sv
// Directed bench for posit_add_sched with NREQ=4, WIDTH=7 and a two-cycle
// modulo-2^WIDTH adder model standing in for the external posit adder.
module tb_posit_add_sched;
    import posit_add_sched_pkg::*;

    localparam int NREQ  = 4;
    localparam int WIDTH = 7;
    localparam int LAT   = 2;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  pause;
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic [WIDTH-1:0]      add_q;
    logic                  res_valid;
    logic [IDW-1:0]        res_id;
    logic [WIDTH-1:0]      res_q;
    logic                  busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] opA [NREQ];
    logic [WIDTH-1:0] opB [NREQ];
    logic [WIDTH-1:0] sumPipe [LAT];

    posit_add_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .EN(1), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .pause     (pause),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_q     (add_q),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_q     (res_q),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Adder stand-in: plain modular sum, LAT cycles after the operands appear.
    always @(posedge clk) begin
        sumPipe[0] <= add_a + add_b;
        for (int i = 1; i < LAT; i++) begin
            sumPipe[i] <= sumPipe[i-1];
        end
    end
    assign add_q = sumPipe[LAT-1];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic setOps(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_a[idx*WIDTH +: WIDTH] = a;
        req_b[idx*WIDTH +: WIDTH] = b;
    endtask

    // Drive one cycle's inputs just after the edge, then sit at the falling edge.
    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic pauseIn);
        @(posedge clk);
        #1;
        req_valid = valid;
        pause     = pauseIn;
        #4;
    endtask

    task automatic doReset(input logic [NREQ-1:0] validDuring, input logic pauseDuring);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = validDuring;
        pause     = pauseDuring;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;
    endtask

    function automatic logic [WIDTH-1:0] expSum(input int idx);
        logic [WIDTH-1:0] s;
        s = opA[idx] + opB[idx];
        return s;
    endfunction

    initial begin
        rst       = 1'b1;
        req_valid = 4'b1111;
        pause     = 1'b0;
        req_a     = '0;
        req_b     = '0;
        opA[0] = 7'h11; opB[0] = 7'h01;
        opA[1] = 7'h22; opB[1] = 7'h33;
        opA[2] = 7'h7F; opB[2] = 7'h02;
        opA[3] = 7'h05; opB[3] = 7'h40;

        @(posedge clk);
        #2;
        checkOutput("rst_ready", req_ready, 4'b0000);
        checkOutput("rst_resv", res_valid, 1'b0);
        checkOutput("rst_resid", res_id, 2'd0);
        checkOutput("rst_resq", res_q, 7'h00);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_adda", add_a, 7'h00);
        checkOutput("rst_addb", add_b, 7'h00);
        checkOutput("rst_state", dut.state_q, IDLE);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;

        // Single request from requester 1
        setOps(1, 7'h20, 7'h20);
        applyStimulus(4'b0010, 1'b0);
        checkOutput("single_ready", req_ready, 4'b0010);
        checkOutput("single_adda", add_a, 7'h20);
        checkOutput("single_addb", add_b, 7'h20);
        checkOutput("single_resv0", res_valid, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("single_ready1", req_ready, 4'b0000);
        checkOutput("single_busy1", busy, 1'b1);
        checkOutput("single_resv1", res_valid, 1'b0);
        checkOutput("single_adda1", add_a, 7'h00);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("single_resv2", res_valid, 1'b1);
        checkOutput("single_resid2", res_id, 2'd1);
        checkOutput("single_resq2", res_q, 7'h40);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("single_resv3", res_valid, 1'b0);
        checkOutput("single_busy3", busy, 1'b0);
        checkOutput("single_resq3", res_q, 7'h00);

        // All four requesters continuously from ptr=0
        doReset(4'b0000, 1'b0);
        for (int i = 0; i < NREQ; i++) begin
            setOps(i, opA[i], opB[i]);
        end
        for (int k = 0; k < 11; k++) begin
            applyStimulus((k < 8) ? 4'b1111 : 4'b0000, 1'b0);
            checkOutput($sformatf("all_ready%0d", k), req_ready, (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000);
            if (k >= 2 && k < 10) begin
                checkOutput($sformatf("all_resv%0d", k), res_valid, 1'b1);
                checkOutput($sformatf("all_resid%0d", k), res_id, (k - 2) % 4);
                checkOutput($sformatf("all_resq%0d", k), res_q, expSum((k - 2) % 4));
            end else begin
                checkOutput($sformatf("all_resv%0d", k), res_valid, 1'b0);
            end
        end

        // Wrap-around fairness with ptr=3
        doReset(4'b0000, 1'b0);
        applyStimulus(4'b0100, 1'b0);
        checkOutput("wrap_ready0", req_ready, 4'b0100);
        applyStimulus(4'b1001, 1'b0);
        checkOutput("wrap_ready1", req_ready, 4'b1000);
        applyStimulus(4'b1001, 1'b0);
        checkOutput("wrap_ready2", req_ready, 4'b0001);
        checkOutput("wrap_resid2", res_id, 2'd2);
        checkOutput("wrap_resq2", res_q, expSum(2));
        applyStimulus(4'b1001, 1'b0);
        checkOutput("wrap_ready3", req_ready, 4'b1000);

        // Four issues then pause: drain and return to idle
        doReset(4'b0000, 1'b0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b1111, 1'b0);
            checkOutput($sformatf("pause_ready%0d", k), req_ready, 4'b0001 << k);
        end
        applyStimulus(4'b1111, 1'b1);
        checkOutput("pause_ready4", req_ready, 4'b0000);
        checkOutput("pause_adda4", add_a, 7'h00);
        checkOutput("pause_state4", dut.state_q, RUN);
        checkOutput("pause_resv4", res_valid, 1'b1);
        checkOutput("pause_resid4", res_id, 2'd2);
        applyStimulus(4'b1111, 1'b1);
        checkOutput("pause_ready5", req_ready, 4'b0000);
        checkOutput("pause_state5", dut.state_q, DRAIN);
        checkOutput("pause_resv5", res_valid, 1'b1);
        checkOutput("pause_resid5", res_id, 2'd3);
        checkOutput("pause_resq5", res_q, expSum(3));
        checkOutput("pause_busy5", busy, 1'b1);
        applyStimulus(4'b1111, 1'b1);
        checkOutput("pause_resv6", res_valid, 1'b0);
        checkOutput("pause_busy6", busy, 1'b0);
        checkOutput("pause_state6", dut.state_q, DRAIN);
        checkOutput("pause_ready6", req_ready, 4'b0000);
        applyStimulus(4'b1111, 1'b1);
        checkOutput("pause_state7", dut.state_q, IDLE);
        checkOutput("pause_ready7", req_ready, 4'b0000);

        // Paused straight out of reset with everyone requesting
        doReset(4'b1111, 1'b1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b1111, 1'b1);
            checkOutput($sformatf("prst_ready%0d", k), req_ready, 4'b0000);
            checkOutput($sformatf("prst_state%0d", k), dut.state_q, IDLE);
            checkOutput($sformatf("prst_adda%0d", k), add_a, 7'h00);
            checkOutput($sformatf("prst_addb%0d", k), add_b, 7'h00);
        end

        // Asynchronous reset with two operations in flight
        applyStimulus(4'b1111, 1'b0);
        checkOutput("arst_ready0", req_ready, 4'b0001);
        applyStimulus(4'b1111, 1'b0);
        checkOutput("arst_ready1", req_ready, 4'b0010);
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        #1;
        checkOutput("arst_resv_pre", res_valid, 1'b1);
        checkOutput("arst_busy_pre", busy, 1'b1);
        #1;
        rst       = 1'b1;
        req_valid = 4'b1111;
        #1;
        checkOutput("arst_resv", res_valid, 1'b0);
        checkOutput("arst_busy", busy, 1'b0);
        checkOutput("arst_ready", req_ready, 4'b0000);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b0000, 1'b0);
            checkOutput($sformatf("arst_quiet_resv%0d", k), res_valid, 1'b0);
            checkOutput($sformatf("arst_quiet_busy%0d", k), busy, 1'b0);
        end
        applyStimulus(4'b0110, 1'b0);
        checkOutput("arst_first_grant", req_ready, 4'b0010);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
